// File: rtl/serial_circular_convolver.sv
// Streaming circular convolver: serial samples -> WIDTH-point frame -> circular convolution -> serial results.
// Define CIRCONV_SATURATE_EN to clamp each result to 2^XLEN-1 instead of wrapping modulo 2^XLEN.
module serial_circular_convolver #(
    parameter int XLEN  = 8,
    parameter int WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WIDTH*XLEN-1:0] weights_i,
    input  logic                  up_valid_i,
    input  logic [XLEN-1:0]       up_data_i,
    output logic                  down_valid_o,
    output logic [XLEN-1:0]       down_data_o
);
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(WIDTH + 1);
    localparam int ACC_W = 2 * XLEN + $clog2(WIDTH);

    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] frame_q [WIDTH];
    logic            frame_valid_q;
    logic [XLEN-1:0] conv_d  [WIDTH];
    logic [XLEN-1:0] res_q   [WIDTH];
    logic            res_valid_q;
    logic [XLEN-1:0] out_vec_q [WIDTH];
    logic [RW-1:0]   remaining_q;
    logic            down_valid_q;
    logic [XLEN-1:0] down_data_q;
    logic [CW-1:0]   emit_idx;

    // Frame assembler: count wraps on the last element and flags a complete frame for one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q       <= '0;
            frame_valid_q <= 1'b0;
            for (int k = 0; k < WIDTH; k++) frame_q[k] <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            if (up_valid_i) begin
                frame_q[count_q] <= up_data_i;
                if (count_q == CW'(WIDTH - 1)) begin
                    count_q       <= '0;
                    frame_valid_q <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    // One output point per generate slice: out[i] = sum_j w[j] * in[(i-j) mod WIDTH].
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_point
        always_comb begin
            logic [2*XLEN-1:0] wx;
            logic [2*XLEN-1:0] xx;
            logic [2*XLEN-1:0] prod;
`ifdef CIRCONV_SATURATE_EN
            logic [ACC_W-1:0]  acc;
            acc = '0;
            for (int j = 0; j < WIDTH; j++) begin
                wx   = {{XLEN{1'b0}}, weights_i[j*XLEN +: XLEN]};
                xx   = {{XLEN{1'b0}}, frame_q[(gi - j + WIDTH) % WIDTH]};
                prod = wx * xx;
                acc  = acc + {{(ACC_W-2*XLEN){1'b0}}, prod};
            end
            if (acc > {{(ACC_W-XLEN){1'b0}}, {XLEN{1'b1}}}) conv_d[gi] = {XLEN{1'b1}};
            else                                              conv_d[gi] = acc[XLEN-1:0];
`else
            logic [XLEN-1:0]   acc;
            acc = '0;
            for (int j = 0; j < WIDTH; j++) begin
                wx   = {{XLEN{1'b0}}, weights_i[j*XLEN +: XLEN]};
                xx   = {{XLEN{1'b0}}, frame_q[(gi - j + WIDTH) % WIDTH]};
                prod = wx * xx;
                acc  = acc + prod[XLEN-1:0];
            end
            conv_d[gi] = acc;
`endif
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)            res_q[gi] <= '0;
            else if (frame_valid_q) res_q[gi] <= conv_d[gi];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) res_valid_q <= 1'b0;
        else         res_valid_q <= frame_valid_q;
    end

    assign emit_idx = CW'(WIDTH - int'(remaining_q));

    // Emitter: element 0 goes out on the load edge itself, so a new load lands exactly
    // when the previous frame's last element leaves and back-to-back frames stay gap-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remaining_q  <= '0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            for (int k = 0; k < WIDTH; k++) out_vec_q[k] <= '0;
        end else if (res_valid_q) begin
            for (int k = 0; k < WIDTH; k++) out_vec_q[k] <= res_q[k];
            remaining_q  <= RW'(WIDTH - 1);
            down_valid_q <= 1'b1;
            down_data_q  <= res_q[0];
        end else if (remaining_q != '0) begin
            remaining_q  <= remaining_q - 1'b1;
            down_valid_q <= 1'b1;
            down_data_q  <= out_vec_q[emit_idx];
        end else begin
            down_valid_q <= 1'b0;
        end
    end

    assign down_valid_o = down_valid_q;
    assign down_data_o  = down_data_q;
endmodule

// File: tb/tb_serial_circular_convolver.sv
// Directed bench for serial_circular_convolver (XLEN=8, WIDTH=16) with hand-computed expected outputs.
module tb_serial_circular_convolver;
    localparam int XLEN  = 8;
    localparam int WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [WIDTH*XLEN-1:0] weights = '0;
    logic                  up_valid = 1'b0;
    logic [XLEN-1:0]       up_data = '0;
    logic                  down_valid;
    logic [XLEN-1:0]       down_data;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int lat;

    serial_circular_convolver #(.XLEN(XLEN), .WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .weights_i   (weights),
        .up_valid_i  (up_valid),
        .up_data_i   (up_data),
        .down_valid_o(down_valid),
        .down_data_o (down_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_single_weight(input int idx, input int val);
        weights = '0;
        weights[idx*XLEN +: XLEN] = XLEN'(val);
    endtask

    task automatic set_all_weights(input int val);
        for (int j = 0; j < WIDTH; j++) weights[j*XLEN +: XLEN] = XLEN'(val);
    endtask

    // Sends n samples; value = start + k*step, optionally a one-cycle gap after each.
    task automatic send(input int n, input int start, input int step, input bit gaps);
        for (int k = 0; k < n; k++) begin
            up_valid = 1'b1;
            up_data  = XLEN'(start + k * step);
            tick();
            if (gaps) begin
                up_valid = 1'b0;
                tick();
            end
        end
        up_valid = 1'b0;
    endtask

    // Waits (bounded) for the first result, then requires n contiguous valid results matching exp_q.
    task automatic collect(input string tag, input int n, output int first_lat);
        first_lat = 0;
        do begin
            tick();
            first_lat++;
        end while (!down_valid && first_lat < 80);
        check_val({tag, "_first_valid"}, int'(down_valid), 1);
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            check_val($sformatf("%s_valid[%0d]", tag, k), int'(down_valid), 1);
            check_val($sformatf("%s_data[%0d]", tag, k), int'(down_data), exp_q[k]);
        end
        tick();
        check_val({tag, "_idle_after"}, int'(down_valid), 0);
    endtask

    initial begin
        #2;
        check_val("reset_valid", int'(down_valid), 0);
        check_val("reset_data", int'(down_data), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Identity with latency check
        set_single_weight(0, 1);
        exp_q = {};
        for (int k = 0; k < 16; k++) exp_q.push_back(k);
        send(16, 0, 1, 1'b0);
        collect("identity", 16, lat);
        check_val("identity_latency", lat, 2);
        $display("identity done");

        // Shift by one
        set_single_weight(1, 1);
        exp_q = {15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        send(16, 0, 1, 1'b0);
        collect("shift", 16, lat);
        $display("shift done");

        // All-ones weights
        set_all_weights(1);
        exp_q = {};
        for (int k = 0; k < 16; k++) exp_q.push_back(48);
        send(16, 3, 0, 1'b0);
        collect("sum3", 16, lat);
        exp_q = {};
        for (int k = 0; k < 16; k++) exp_q.push_back(120);
        send(16, 0, 1, 1'b0);
        collect("sum_ramp", 16, lat);
        $display("sum done");

        // Overflow: 16 * 16 = 256
        set_single_weight(0, 16);
        exp_q = {};
`ifdef CIRCONV_SATURATE_EN
        for (int k = 0; k < 16; k++) exp_q.push_back(255);
`else
        for (int k = 0; k < 16; k++) exp_q.push_back(0);
`endif
        send(16, 16, 0, 1'b0);
        collect("overflow", 16, lat);
        $display("overflow done");

        // Gapped input
        set_single_weight(0, 1);
        exp_q = {};
        for (int k = 0; k < 16; k++) exp_q.push_back(k);
        send(16, 0, 1, 1'b1);
        collect("gaps", 16, lat);
        $display("gaps done");

        // Two back-to-back frames must give 32 contiguous outputs
        exp_q = {};
        for (int k = 0; k < 32; k++) exp_q.push_back(k);
        fork
            send(32, 0, 1, 1'b0);
            collect("b2b", 32, lat);
        join
        $display("back-to-back done");

        // Reset mid-frame discards the partial frame
        send(5, 50, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid", int'(down_valid), 0);
        check_val("midrst_data", int'(down_data), 0);
        tick();
        tick();
        check_val("midrst_valid_hold", int'(down_valid), 0);
        check_val("midrst_data_hold", int'(down_data), 0);
        rst_n = 1'b1;
        tick();
        exp_q = {};
        for (int k = 0; k < 16; k++) exp_q.push_back(100 + k);
        send(16, 100, 1, 1'b0);
        collect("post_reset", 16, lat);
        check_val("post_reset_latency", lat, 2);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_val("post_reset_no_extra", int'(down_valid), 0);
        end
        $display("reset mid-frame done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
